full_adder: RTL and testbench

//   Registered WIDTH-bit ripple-carry adder: {C_out,S} = A + B + C_in.

---
 rtl/full_adder.sv | 84 ++++++++
 tb/tb_full_adder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/full_adder.sv
// Registered WIDTH-bit ripple-carry adder built from 1-bit full-adder cells.
// Ports: clock, reset (sync, active-high), in_valid, A, B, C_in -> S, C_out, V, out_valid.
module full_adder #(
  parameter int WIDTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  output logic [WIDTH-1:0] S,
  output logic             C_out,
  output logic             V,
  output logic             out_valid
);

  // One full-adder cell: returns {carry_out, sum}.
  function automatic logic [1:0] fa_cell(
    input logic a,
    input logic b,
    input logic c
  );
    logic s;
    logic co;
    s  = a ^ b ^ c;
    co = (a & b) | (a & c) | (b & c);
    return {co, s};
  endfunction

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;

  logic [WIDTH-1:0] s_d, s_q;
  logic             c_out_d, c_out_q;
  logic             v_d, v_q;
  logic             out_valid_d, out_valid_q;

  // Carry chain lives in one block so the ripple stays a single
  // combinational node.
  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = C_in;
    for (int i = 0; i < WIDTH; i++) begin
      {carry[i+1], sum[i]} = fa_cell(A[i], B[i], carry[i]);
    end
  end

  // Results only move on a valid input; otherwise hold so that
  // undriven operands cannot disturb the outputs.
  always_comb begin
    s_d         = s_q;
    c_out_d     = c_out_q;
    v_d         = v_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      s_d         = sum;
      c_out_d     = carry[WIDTH];
      v_d         = carry[WIDTH-1] ^ carry[WIDTH];
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s_q         <= '0;
      c_out_q     <= 1'b0;
      v_q         <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s_q         <= s_d;
      c_out_q     <= c_out_d;
      v_q         <= v_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign S         = s_q;
  assign C_out     = c_out_q;
  assign V         = v_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_full_adder.sv
// Directed/random bench for full_adder at WIDTH=2 and WIDTH=8.
// Each scenario task drives stimulus and checks results inline.
module tb_full_adder;

  logic clock;
  logic reset;

  logic       v_in2;
  logic [1:0] a2, b2;
  logic       cin2;
  logic [1:0] s2;
  logic       co2, ov2, vo2;

  logic       v_in8;
  logic [7:0] a8, b8;
  logic       cin8;
  logic [7:0] s8;
  logic       co8, ov8, vo8;

  int passed;
  int total;

  full_adder #(.WIDTH(2)) u_fa2 (
    .clock    (clock),
    .reset    (reset),
    .in_valid (v_in2),
    .A        (a2),
    .B        (b2),
    .C_in     (cin2),
    .S        (s2),
    .C_out    (co2),
    .V        (ov2),
    .out_valid(vo2)
  );

  full_adder #(.WIDTH(8)) u_fa8 (
    .clock    (clock),
    .reset    (reset),
    .in_valid (v_in8),
    .A        (a8),
    .B        (b8),
    .C_in     (cin8),
    .S        (s8),
    .C_out    (co8),
    .V        (ov8),
    .out_valid(vo8)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    logic [4:0] got;
    reset = 1'b1;
    v_in2 = 1'b1; a2 = 2'd3; b2 = 2'd3; cin2 = 1'b1;
    v_in8 = 1'b1; a8 = 8'd3; b8 = 8'd3; cin8 = 1'b1;
    tick();
    tick();
    got = {vo2, ov2, co2, s2};
    total++;
    if (got !== 5'b0)
      $display("FAIL reset_w2 got=%b want=00000", got);
    else passed++;
    total++;
    if ({vo8, ov8, co8, s8} !== 11'b0)
      $display("FAIL reset_w8 got=%b want=0", {vo8, ov8, co8, s8});
    else passed++;
    reset = 1'b0;
    v_in8 = 1'b0;
  endtask

  // Every (A,B,C_in) applied on consecutive cycles: also exercises
  // back-to-back throughput, since each result must appear next cycle.
  task automatic test_exhaustive();
    logic [2:0] want;
    logic       want_v;
    logic [1:0] ws;
    for (int i = 0; i < 32; i++) begin
      v_in2 = 1'b1;
      a2    = i[4:3];
      b2    = i[2:1];
      cin2  = i[0];
      want  = {1'b0, a2} + {1'b0, b2} + {2'b0, cin2};
      ws    = want[1:0];
      want_v = (a2[1] == b2[1]) && (ws[1] != a2[1]);
      tick();
      total++;
      if ({vo2, ov2, co2, s2} !== {1'b1, want_v, want})
        $display("FAIL exh a=%0d b=%0d c=%0d got v=%b ov=%b sum=%0d want ov=%b sum=%0d",
                 a2, b2, cin2, vo2, ov2, {co2, s2}, want_v, want);
      else passed++;
    end
  endtask

  task automatic test_corners();
    v_in2 = 1'b1; a2 = 2'd0; b2 = 2'd0; cin2 = 1'b0;
    tick();
    total++;
    if ({co2, s2, ov2} !== 4'b0_00_0)
      $display("FAIL corner_zero got co=%b s=%0d v=%b want 0/0/0", co2, s2, ov2);
    else passed++;
    a2 = 2'd3; b2 = 2'd3; cin2 = 1'b1;
    tick();
    total++;
    if ({co2, s2} !== 3'b1_11)
      $display("FAIL corner_wrap got co=%b s=%0d want co=1 s=3", co2, s2);
    else passed++;
    a2 = 2'd1; b2 = 2'd0; cin2 = 1'b1;
    tick();
    total++;
    if ({co2, s2, ov2} !== 4'b0_10_1)
      $display("FAIL corner_ovf got co=%b s=%0d v=%b want co=0 s=2 v=1", co2, s2, ov2);
    else passed++;
  endtask

  task automatic test_hold();
    v_in2 = 1'b1; a2 = 2'd2; b2 = 2'd1; cin2 = 1'b0;
    tick();
    total++;
    if ({vo2, s2} !== 3'b1_11)
      $display("FAIL hold_load got v=%b s=%0d want v=1 s=3", vo2, s2);
    else passed++;
    v_in2 = 1'b0; a2 = 2'd0; b2 = 2'd0;
    tick();
    total++;
    if ({vo2, co2, s2} !== 4'b0_0_11)
      $display("FAIL hold_zero got v=%b co=%b s=%0d want v=0 co=0 s=3", vo2, co2, s2);
    else passed++;
    a2 = 2'bxx; b2 = 2'bzz; cin2 = 1'bx;
    tick();
    total++;
    if ({vo2, co2, s2} !== 4'b0_0_11)
      $display("FAIL hold_x got v=%b co=%b s=%0d want v=0 co=0 s=3", vo2, co2, s2);
    else passed++;
    cin2 = 1'b0;
  endtask

  task automatic test_reset_midstream();
    v_in2 = 1'b1; a2 = 2'd1; b2 = 2'd1; cin2 = 1'b0;
    tick();
    total++;
    if ({vo2, co2, s2} !== 4'b1_0_10)
      $display("FAIL mid_pre got v=%b sum=%0d want v=1 sum=2", vo2, {co2, s2});
    else passed++;
    reset = 1'b1; a2 = 2'd3; b2 = 2'd2; cin2 = 1'b1;
    tick();
    total++;
    if ({vo2, ov2, co2, s2} !== 5'b0)
      $display("FAIL mid_reset got %b want 00000", {vo2, ov2, co2, s2});
    else passed++;
    reset = 1'b0; a2 = 2'd2; b2 = 2'd3; cin2 = 1'b0;
    tick();
    total++;
    if ({vo2, co2, s2} !== 4'b1_1_01)
      $display("FAIL mid_resume got v=%b sum=%0d want v=1 sum=5", vo2, {co2, s2});
    else passed++;
  endtask

  task automatic test_random_w8();
    logic [8:0] want;
    logic       want_v;
    int         bad;
    bad = 0;
    v_in2 = 1'b0;
    for (int i = 0; i < 1001; i++) begin
      v_in8 = 1'b1;
      if (i == 0) begin
        a8 = 8'd255; b8 = 8'd255; cin8 = 1'b1;
      end else begin
        a8   = 8'($urandom_range(0, 255));
        b8   = 8'($urandom_range(0, 255));
        cin8 = 1'($urandom_range(0, 1));
      end
      want   = {1'b0, a8} + {1'b0, b8} + {8'b0, cin8};
      want_v = (a8[7] == b8[7]) && (want[7] != a8[7]);
      tick();
      total++;
      if ({vo8, ov8, co8, s8} !== {1'b1, want_v, want}) begin
        if (bad < 10)
          $display("FAIL rand_w8 a=%0d b=%0d c=%0d got ov=%b sum=%0d want ov=%b sum=%0d",
                   a8, b8, cin8, ov8, {co8, s8}, want_v, want);
        bad++;
      end else passed++;
    end
    v_in8 = 1'b0;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    reset  = 1'b1;
    v_in2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
    v_in8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    test_reset();
    test_exhaustive();
    test_corners();
    test_hold();
    test_reset_midstream();
    test_random_w8();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
